// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths,
// common to the APB master controller and the APB slave.
package apb_pkg;

  localparam int AMBA_WORD_DEFAULT       = 32;
  localparam int AMBA_ADDR_WIDTH_DEFAULT = 20;
  localparam int TIMEOUT_CYCLES_DEFAULT  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

endpackage

// File: rtl/apb_master_ctrl.sv
// APB master: turns a valid/ready command into one SETUP/ACCESS transfer and
// returns a single-cycle response, aborting the transfer on wait-state timeout.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int AMBA_WORD       = AMBA_WORD_DEFAULT,
  parameter int AMBA_ADDR_WIDTH = AMBA_ADDR_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  // Command handshake: a command transfers on a rising edge where
  // cmd_valid and cmd_ready are both 1; cmd_ready is high only in IDLE.
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       rsp_err,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       PREADY,
  input  logic                       PSLVERR
);

  // Last counter value tolerated before the transfer is aborted.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  apb_state_t                 state, state_nxt;
  logic [7:0]                 cnt, cnt_nxt;
  logic                       psel_nxt, penable_nxt, pwrite_nxt;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_nxt;
  logic [AMBA_WORD-1:0]       pwdata_nxt;
  logic                       rsp_valid_nxt, rsp_err_nxt;
  logic [AMBA_WORD-1:0]       rsp_rdata_nxt;

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      PSEL      <= psel_nxt;
      PENABLE   <= penable_nxt;
      PWRITE    <= pwrite_nxt;
      PADDR     <= paddr_nxt;
      PWDATA    <= pwdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    psel_nxt      = PSEL;
    penable_nxt   = PENABLE;
    pwrite_nxt    = PWRITE;
    paddr_nxt     = PADDR;
    pwdata_nxt    = PWDATA;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = rsp_err;
    rsp_rdata_nxt = rsp_rdata;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt  = SETUP;
          psel_nxt   = 1'b1;
          pwrite_nxt = cmd_write;
          paddr_nxt  = cmd_addr;
          pwdata_nxt = cmd_wdata;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
      end
      ACCESS: begin
        // A slave completing in the final allowed cycle wins over the timeout.
        if (PREADY) begin
          state_nxt     = IDLE;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = PSLVERR;
          rsp_rdata_nxt = PWRITE ? '0 : PRDATA;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt     = IDLE;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_rdata_nxt = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase
  end

endmodule
